mbist_march_engine: RTL and testbench

Parametrised next-generation MBIST controller for a single-port SRAM with 1-cycle read latency. It generates address, data and write/read strobes for three selectable algorithms: MSCAN, CheckerBoard and March C-. It compares read data in a pipelined fashion and reports pass/fail, a saturating fail count, and first-fail diagnostics. It sits between the test-mode top level and the SRAM under test; width and depth are set by parameters.

---
 rtl/mbist_march_engine.sv | 279 +++++++++++++++++++++++++++
 tb/tb_mbist_march_engine.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mbist_march_engine.sv
// MBIST march engine: sequences MSCAN, CheckerBoard and March C- over a single-port
// SRAM with 1-cycle read latency, comparing read data one cycle after each read strobe.
module mbist_march_engine #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              nRESET,
    input  logic              MBISTEN,
    input  logic [1:0]        TESTTYPE,
    output logic [ADDR_W-1:0] ADDR_MBIST,
    output logic [DATA_W-1:0] DATA_MBIST,
    output logic              iWrite,
    output logic              iRead,
    input  logic [DATA_W-1:0] DATA_DUT,
    output logic              BUSY,
    output logic              DONE,
    output logic              RESULT,
    output logic [CNT_W-1:0]  FAIL_CNT,
    output logic [ADDR_W-1:0] FAIL_ADDR,
    output logic [DATA_W-1:0] FAIL_DATA,
    output logic [2:0]        FAIL_ELEM
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [1:0] T_MSCAN = 2'd0;
    localparam logic [1:0] T_CKBD  = 2'd1;
    localparam logic [1:0] T_MARCH = 2'd2;
    localparam logic [1:0] T_RSVD  = 2'd3;

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [DATA_W-1:0] ONES     = '1;
    localparam logic [DATA_W-1:0] ZEROS    = '0;
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    function automatic logic f_two_op(input logic [1:0] tt, input logic [2:0] el);
        return (tt == T_MARCH) && (el >= 3'd1) && (el <= 3'd4);
    endfunction

    function automatic logic f_desc(input logic [1:0] tt, input logic [2:0] el);
        return (tt == T_MARCH) && ((el == 3'd3) || (el == 3'd4));
    endfunction

    function automatic logic [2:0] f_last_elem(input logic [1:0] tt);
        return (tt == T_MARCH) ? 3'd5 : 3'd3;
    endfunction

    function automatic logic f_is_read(input logic [1:0] tt, input logic [2:0] el,
                                       input logic ph);
        if (tt == T_MARCH) begin
            return (el == 3'd5) || (f_two_op(tt, el) && !ph);
        end
        return el[0];
    endfunction

    // Checkerboard word is 0x55.. on even addresses and 0xAA.. on odd ones.
    function automatic logic [DATA_W-1:0] f_data(input logic [1:0] tt, input logic [2:0] el,
                                                  input logic ph, input logic a0);
        logic [DATA_W-1:0] ckbd;
        for (int i = 0; i < DATA_W; i++) begin
            ckbd[i] = ~(i[0] ^ a0);
        end
        case (tt)
            T_MSCAN: return el[1] ? ONES : ZEROS;
            T_CKBD:  return el[1] ? ~ckbd : ckbd;
            default: begin
                case (el)
                    3'd1, 3'd3: return ph ? ONES : ZEROS;
                    3'd2, 3'd4: return ph ? ZEROS : ONES;
                    default:    return ZEROS;
                endcase
            end
        endcase
    endfunction

    logic [1:0]        state_q, state_d;
    logic              mbisten_prev_q;
    logic [1:0]        ttype_q, ttype_d;
    logic [2:0]        elem_q, elem_d;
    logic              phase_q, phase_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              iwrite_q, iwrite_d;
    logic              iread_q, iread_d;
    logic              done_q, done_d;
    logic              result_q, result_d;
    logic              cmp_valid_q, cmp_valid_d;
    logic [DATA_W-1:0] exp_data_q, exp_data_d;
    logic [ADDR_W-1:0] exp_addr_q, exp_addr_d;
    logic [2:0]        exp_elem_q, exp_elem_d;
    logic [CNT_W-1:0]  fail_cnt_q, fail_cnt_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [DATA_W-1:0] fail_data_q, fail_data_d;
    logic [2:0]        fail_elem_q, fail_elem_d;

    logic              start_edge;
    logic              mismatch;
    logic [2:0]        nxt_elem;
    logic              nxt_phase;
    logic [ADDR_W-1:0] nxt_addr;
    logic              last_op;
    logic              nxt_rd;

    assign start_edge = MBISTEN && !mbisten_prev_q;
    assign mismatch   = cmp_valid_q && (DATA_DUT != exp_data_q);

    // Operation sequencer: from the op on the strobes now, derive the next one.
    always_comb begin
        nxt_elem  = elem_q;
        nxt_phase = 1'b0;
        nxt_addr  = addr_q;
        last_op   = 1'b0;
        if (f_two_op(ttype_q, elem_q) && !phase_q) begin
            nxt_phase = 1'b1;
        end else if (addr_q == (f_desc(ttype_q, elem_q) ? '0 : ADDR_MAX)) begin
            if (elem_q == f_last_elem(ttype_q)) begin
                last_op = 1'b1;
            end else begin
                nxt_elem = elem_q + 3'd1;
                nxt_addr = f_desc(ttype_q, elem_q + 3'd1) ? ADDR_MAX : '0;
            end
        end else begin
            nxt_addr = f_desc(ttype_q, elem_q) ? addr_q - 1'b1 : addr_q + 1'b1;
        end
        nxt_rd = f_is_read(ttype_q, nxt_elem, nxt_phase);
    end

    always_comb begin
        state_d  = state_q;
        ttype_d  = ttype_q;
        elem_d   = elem_q;
        phase_d  = phase_q;
        addr_d   = addr_q;
        data_d   = data_q;
        iwrite_d = 1'b0;
        iread_d  = 1'b0;
        done_d   = done_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                done_d   = 1'b0;
                result_d = 1'b0;
                if (start_edge) begin
                    ttype_d = TESTTYPE;
                    if (TESTTYPE == T_RSVD) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = S_RUN;
                        elem_d   = 3'd0;
                        phase_d  = 1'b0;
                        addr_d   = '0;
                        data_d   = f_data(TESTTYPE, 3'd0, 1'b0, 1'b0);
                        iwrite_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (!MBISTEN) begin
                    state_d = S_IDLE;
                end else if (last_op) begin
                    state_d = S_DRAIN;
                end else begin
                    elem_d   = nxt_elem;
                    phase_d  = nxt_phase;
                    addr_d   = nxt_addr;
                    data_d   = f_data(ttype_q, nxt_elem, nxt_phase, nxt_addr[0]);
                    iread_d  = nxt_rd;
                    iwrite_d = !nxt_rd;
                end
            end
            S_DRAIN: begin
                if (!MBISTEN) begin
                    state_d = S_IDLE;
                end else begin
                    state_d  = S_DONE;
                    done_d   = 1'b1;
                    result_d = (fail_cnt_d == '0);
                end
            end
            default: begin
                if (!MBISTEN) begin
                    state_d  = S_IDLE;
                    done_d   = 1'b0;
                    result_d = 1'b0;
                end
            end
        endcase
    end

    // Compare pipeline: a read registers its expectation, DATA_DUT is checked a cycle later.
    always_comb begin
        cmp_valid_d = iread_q && MBISTEN;
        exp_data_d  = data_q;
        exp_addr_d  = addr_q;
        exp_elem_d  = elem_q;
        fail_cnt_d  = fail_cnt_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
        fail_elem_d = fail_elem_q;
        if (start_edge && (state_q == S_IDLE)) begin
            fail_cnt_d  = '0;
            fail_addr_d = '0;
            fail_data_d = '0;
            fail_elem_d = '0;
        end else if (mismatch) begin
            if (fail_cnt_q != CNT_MAX) begin
                fail_cnt_d = fail_cnt_q + 1'b1;
            end
            if (fail_cnt_q == '0) begin
                fail_addr_d = exp_addr_q;
                fail_data_d = DATA_DUT;
                fail_elem_d = exp_elem_q;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q        <= S_IDLE;
            mbisten_prev_q <= 1'b0;
            ttype_q        <= '0;
            elem_q         <= '0;
            phase_q        <= 1'b0;
            addr_q         <= '0;
            data_q         <= '0;
            iwrite_q       <= 1'b0;
            iread_q        <= 1'b0;
            done_q         <= 1'b0;
            result_q       <= 1'b0;
            cmp_valid_q    <= 1'b0;
            exp_data_q     <= '0;
            exp_addr_q     <= '0;
            exp_elem_q     <= '0;
            fail_cnt_q     <= '0;
            fail_addr_q    <= '0;
            fail_data_q    <= '0;
            fail_elem_q    <= '0;
        end else begin
            state_q        <= state_d;
            mbisten_prev_q <= MBISTEN;
            ttype_q        <= ttype_d;
            elem_q         <= elem_d;
            phase_q        <= phase_d;
            addr_q         <= addr_d;
            data_q         <= data_d;
            iwrite_q       <= iwrite_d;
            iread_q        <= iread_d;
            done_q         <= done_d;
            result_q       <= result_d;
            cmp_valid_q    <= cmp_valid_d;
            exp_data_q     <= exp_data_d;
            exp_addr_q     <= exp_addr_d;
            exp_elem_q     <= exp_elem_d;
            fail_cnt_q     <= fail_cnt_d;
            fail_addr_q    <= fail_addr_d;
            fail_data_q    <= fail_data_d;
            fail_elem_q    <= fail_elem_d;
        end
    end

    assign ADDR_MBIST = addr_q;
    assign DATA_MBIST = data_q;
    assign iWrite     = iwrite_q;
    assign iRead      = iread_q;
    assign BUSY       = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign DONE       = done_q;
    assign RESULT     = result_q;
    assign FAIL_CNT   = fail_cnt_q;
    assign FAIL_ADDR  = fail_addr_q;
    assign FAIL_DATA  = fail_data_q;
    assign FAIL_ELEM  = fail_elem_q;

endmodule

// File: tb/tb_mbist_march_engine.sv
// Directed bench for mbist_march_engine: 16x8 SRAM model with optional stuck-at and
// invert-on-read faults, an expected operation list per algorithm, and a 2-bit fail counter.
module tb_mbist_march_engine;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int CW = 2;

    logic          CLK;
    logic          nRESET;
    logic          MBISTEN;
    logic [1:0]    TESTTYPE;
    logic [AW-1:0] ADDR_MBIST;
    logic [DW-1:0] DATA_MBIST;
    logic          iWrite;
    logic          iRead;
    logic [DW-1:0] DATA_DUT;
    logic          BUSY;
    logic          DONE;
    logic          RESULT;
    logic [CW-1:0] FAIL_CNT;
    logic [AW-1:0] FAIL_ADDR;
    logic [DW-1:0] FAIL_DATA;
    logic [2:0]    FAIL_ELEM;

    mbist_march_engine #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
        .CLK(CLK), .nRESET(nRESET), .MBISTEN(MBISTEN), .TESTTYPE(TESTTYPE),
        .ADDR_MBIST(ADDR_MBIST), .DATA_MBIST(DATA_MBIST), .iWrite(iWrite), .iRead(iRead),
        .DATA_DUT(DATA_DUT), .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT),
        .FAIL_CNT(FAIL_CNT), .FAIL_ADDR(FAIL_ADDR), .FAIL_DATA(FAIL_DATA), .FAIL_ELEM(FAIL_ELEM)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // SRAM model: write on the strobe edge, read data registered for the next cycle.
    logic [DW-1:0] mem [16];
    logic [DW-1:0] rdData;
    int            faultMode;
    assign DATA_DUT = rdData;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        rdData = '0;
    end

    always @(posedge CLK) begin
        if (iWrite) mem[ADDR_MBIST] <= DATA_MBIST;
        if (iRead) begin
            if (faultMode == 2)
                rdData <= ~mem[ADDR_MBIST];
            else if (faultMode == 1 && ADDR_MBIST == 4'd5)
                rdData <= mem[ADDR_MBIST] | 8'h08;
            else
                rdData <= mem[ADDR_MBIST];
        end
    end

    int totalChecks = 0;
    int badChecks   = 0;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        totalChecks++;
        if (got !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    bit            expWr[$];
    logic [AW-1:0] expAddr[$];
    logic [DW-1:0] expData[$];

    task automatic pushOp(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        expWr.push_back(wr);
        expAddr.push_back(a);
        expData.push_back(d);
    endtask

    task automatic buildExpected(input logic [1:0] tt);
        expWr.delete();
        expAddr.delete();
        expData.delete();
        if (tt == 2'd2) begin
            for (int a = 0; a < 16; a++) pushOp(1'b1, a[3:0], 8'h00);
            for (int a = 0; a < 16; a++) begin pushOp(1'b0, a[3:0], 8'h00); pushOp(1'b1, a[3:0], 8'hFF); end
            for (int a = 0; a < 16; a++) begin pushOp(1'b0, a[3:0], 8'hFF); pushOp(1'b1, a[3:0], 8'h00); end
            for (int a = 15; a >= 0; a--) begin pushOp(1'b0, a[3:0], 8'h00); pushOp(1'b1, a[3:0], 8'hFF); end
            for (int a = 15; a >= 0; a--) begin pushOp(1'b0, a[3:0], 8'hFF); pushOp(1'b1, a[3:0], 8'h00); end
            for (int a = 0; a < 16; a++) pushOp(1'b0, a[3:0], 8'h00);
        end else begin
            for (int e = 0; e < 4; e++) begin
                for (int a = 0; a < 16; a++) begin
                    logic [DW-1:0] d;
                    if (tt == 2'd0) d = (e >= 2) ? 8'hFF : 8'h00;
                    else begin
                        d = a[0] ? 8'hAA : 8'h55;
                        if (e >= 2) d = ~d;
                    end
                    pushOp((e % 2) == 0, a[3:0], d);
                end
            end
        end
    endtask

    int nStrobes, seqErrs, busyErrs, firstStrobe, lastStrobe, doneCycle;
    logic [CW-1:0] cntAtStart;

    // Raise MBISTEN and watch every cycle until DONE, comparing strobes with the op list.
    task automatic applyStimulus(input logic [1:0] tt);
        int idx;
        buildExpected(tt);
        idx = 0; seqErrs = 0; busyErrs = 0;
        firstStrobe = -1; lastStrobe = -1; doneCycle = -1; cntAtStart = '1;
        @(negedge CLK);
        TESTTYPE = tt;
        MBISTEN  = 1'b1;
        for (int c = 1; c <= 2000 && doneCycle < 0; c++) begin
            @(negedge CLK);
            if (c == 1) cntAtStart = FAIL_CNT;
            if (iWrite || iRead) begin
                if (firstStrobe < 0) firstStrobe = c;
                lastStrobe = c;
                if (iWrite && iRead) seqErrs++;
                else if (idx >= expWr.size()) seqErrs++;
                else if (iWrite != expWr[idx] || ADDR_MBIST != expAddr[idx] ||
                         (iWrite && DATA_MBIST != expData[idx])) seqErrs++;
                if (!BUSY) busyErrs++;
                idx++;
            end else if (firstStrobe > 0 && idx < expWr.size()) begin
                seqErrs++;
            end
            if (DONE) doneCycle = c;
        end
        nStrobes = idx;
    endtask

    task automatic checkRun(input int expLen, input bit expResult, input int expCnt);
        checkOutput("strobe_count", nStrobes, expLen);
        checkOutput("op_sequence_errs", seqErrs, 0);
        checkOutput("busy_errs", busyErrs, 0);
        checkOutput("first_strobe_cycle", firstStrobe, 1);
        checkOutput("done_latency", doneCycle - lastStrobe, 2);
        checkOutput("cnt_cleared_at_start", cntAtStart, 0);
        checkOutput("result", RESULT, expResult);
        checkOutput("fail_cnt", FAIL_CNT, expCnt);
    endtask

    // Keep MBISTEN high past DONE (must not restart), then drop it and expect DONE to clear.
    task automatic releaseRun();
        int extra;
        extra = 0;
        repeat (3) begin
            @(negedge CLK);
            if (iWrite || iRead || BUSY || !DONE) extra++;
        end
        checkOutput("no_restart_when_held", extra, 0);
        MBISTEN = 1'b0;
        @(negedge CLK);
        checkOutput("done_result_cleared", {DONE, RESULT}, 0);
    endtask

    initial begin
        nRESET    = 1'b0;
        MBISTEN   = 1'b0;
        TESTTYPE  = 2'd0;
        faultMode = 0;
        #3;
        checkOutput("reset_outputs", {ADDR_MBIST, DATA_MBIST, iWrite, iRead, BUSY, DONE, RESULT,
                                      FAIL_CNT, FAIL_ADDR, FAIL_DATA, FAIL_ELEM}, 0);
        repeat (2) @(negedge CLK);
        nRESET = 1'b1;

        $display("[TB] MSCAN, ideal SRAM");
        applyStimulus(2'd0);
        checkRun(64, 1'b1, 0);
        releaseRun();

        $display("[TB] March C-, ideal SRAM");
        applyStimulus(2'd2);
        checkRun(160, 1'b1, 0);
        releaseRun();

        $display("[TB] CheckerBoard, ideal SRAM");
        applyStimulus(2'd1);
        checkRun(64, 1'b1, 0);
        checkOutput("ckbd_final_mem0", mem[0], 8'hAA);
        checkOutput("ckbd_final_mem1", mem[1], 8'h55);
        releaseRun();

        $display("[TB] March C-, bit 3 of addr 5 stuck at 1");
        faultMode = 1;
        applyStimulus(2'd2);
        checkRun(160, 1'b0, 3);
        checkOutput("stuck_fail_elem", FAIL_ELEM, 1);
        checkOutput("stuck_fail_addr", FAIL_ADDR, 5);
        checkOutput("stuck_fail_data", FAIL_DATA, 8'h08);
        releaseRun();

        $display("[TB] abort during element 2, then restart");
        @(negedge CLK);
        TESTTYPE = 2'd2;
        MBISTEN  = 1'b1;
        repeat (56) @(negedge CLK);
        MBISTEN = 1'b0;
        @(negedge CLK);
        checkOutput("abort_strobes", {iWrite, iRead}, 0);
        checkOutput("abort_busy_done", {BUSY, DONE}, 0);
        checkOutput("abort_cnt_kept", FAIL_CNT, 1);
        checkOutput("abort_elem_kept", FAIL_ELEM, 1);
        checkOutput("abort_addr_kept", FAIL_ADDR, 5);
        applyStimulus(2'd2);
        checkRun(160, 1'b0, 3);
        checkOutput("restart_fail_elem", FAIL_ELEM, 1);
        releaseRun();

        $display("[TB] MSCAN, every read inverted");
        faultMode = 2;
        applyStimulus(2'd0);
        checkRun(64, 1'b0, 3);
        checkOutput("sat_fail_elem", FAIL_ELEM, 1);
        checkOutput("sat_fail_addr", FAIL_ADDR, 0);
        checkOutput("sat_fail_data", FAIL_DATA, 8'hFF);
        releaseRun();

        $display("[TB] reserved test type");
        faultMode = 0;
        @(negedge CLK);
        TESTTYPE = 2'd3;
        MBISTEN  = 1'b1;
        @(negedge CLK);
        checkOutput("rsvd_done_result", {DONE, RESULT}, 2'b10);
        checkOutput("rsvd_busy_strobes", {BUSY, iWrite, iRead}, 0);
        checkOutput("rsvd_fail_cnt", FAIL_CNT, 0);
        releaseRun();

        $display("[TB] async reset mid-run");
        @(negedge CLK);
        TESTTYPE = 2'd0;
        MBISTEN  = 1'b1;
        repeat (20) @(negedge CLK);
        checkOutput("pre_reset_busy", BUSY, 1);
        #2 nRESET = 1'b0;
        #1;
        checkOutput("async_reset_outputs", {ADDR_MBIST, DATA_MBIST, iWrite, iRead, BUSY, DONE,
                                            RESULT, FAIL_CNT, FAIL_ADDR, FAIL_DATA, FAIL_ELEM}, 0);
        MBISTEN = 1'b0;
        @(negedge CLK);
        nRESET = 1'b1;
        @(negedge CLK);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
